// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the DFF bank arbiter: state encoding, default sizes
// and small index helpers used by the arbiter and its round-robin picker.
package dff_bank_arbiter_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Index width for a pointer over n requesters; a single requester still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (a + b) mod n for a, b < n, without a divider.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_chk.sv
// Property checker for the arbiter handshake outputs; instantiated alongside
// the arbiter in simulation.
module dff_bank_arbiter_chk
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input logic             clk,
    input logic             reset,
    input logic [N_REQ-1:0] gnt,
    input logic [N_REQ-1:0] ack,
    input logic             busy
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(ack));
    a_ack_in_gnt:  assert property (@(posedge clk) disable iff (!reset) ((ack & ~gnt) == '0));
    a_busy_gnt:    assert property (@(posedge clk) disable iff (!reset) (busy == (gnt != '0)));

endmodule

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit at or after the
// pointer, scanning upward and wrapping at N_REQ.
module rr_pick
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PW    = ptr_w(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_pointer,
    output logic [PW-1:0]    o_winner,
    output logic             o_valid
);

    logic [PW-1:0] w_idx [N_REQ];

    // Requester index visited at each scan offset from the pointer.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            w_idx[k] = PW'(wrap_add(32'(i_pointer), 32'(k), 32'(N_REQ)));
        end
    end

    // Scan from the farthest offset down so the nearest set bit overrides the rest.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            o_winner = i_req[w_idx[k]] ? w_idx[k] : o_winner;
            o_valid  = o_valid | i_req[w_idx[k]];
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Shared register written by N_REQ requesters through a three-state
// IDLE/GRANT/ACK handshake with round-robin arbitration.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [CNT_W-1:0]       wr_count
);

    localparam int PW = ptr_w(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1'b1);

    state_e           r_state;
    state_e           w_state_next;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] w_gnt_next;
    logic [N_REQ-1:0] w_ack_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hold;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_winner;
    logic [PW-1:0]    w_pick;
    logic             w_pick_valid;
    logic             r_busy;
    logic             w_load_hold;
    logic             w_commit;
    logic             w_adv_ptr;
    logic [CNT_W-1:0] r_wr_count;
    logic [WIDTH-1:0] w_lane [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req     (req),
        .i_pointer (r_ptr),
        .o_winner  (w_pick),
        .o_valid   (w_pick_valid)
    );

    // Split the flattened write bus into per-requester lanes.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            w_lane[k] = wdata[k*WIDTH +: WIDTH];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-edge transaction controls.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_ack_next   = '0;
        w_load_hold  = 1'b0;
        w_commit     = 1'b0;
        w_adv_ptr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = ST_GRANT;
                    w_gnt_next   = ONE_HOT0 << w_pick;
                    w_load_hold  = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = '0;
                end
            end
            ST_GRANT: begin
                // Only the winner's own request is watched; a dropped request aborts quietly.
                if (req[r_winner]) begin
                    w_state_next = ST_ACK;
                    w_ack_next   = r_gnt;
                    w_commit     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = '0;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
                w_adv_ptr    = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt      <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_q        <= '0;
            r_hold     <= '0;
            r_winner   <= '0;
            r_ptr      <= '0;
            r_wr_count <= '0;
        end else begin
            r_gnt  <= w_gnt_next;
            r_ack  <= w_ack_next;
            r_busy <= (w_state_next != ST_IDLE);
            if (w_load_hold) begin
                r_hold   <= w_lane[w_pick];
                r_winner <= w_pick;
            end
            if (w_commit) begin
                r_q        <= r_hold;
                r_wr_count <= r_wr_count + CNT_W'(1'b1);
            end
            if (w_adv_ptr) begin
                r_ptr <= PW'(wrap_add(32'(r_winner), 32'd1, 32'(N_REQ)));
            end
        end
    end

    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign q        = r_q;
    assign busy     = r_busy;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: each expected write is queued when its
// request is driven and checked when the matching ack pulse appears.
module tb_dff_bank_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  lane [4];
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    logic [7:0]  wr_count;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb [$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_ptr    = 0;
    logic [7:0] m_cnt    = 8'd0;
    logic [7:0] m_q      = 8'd0;

    assign wdata = {lane[3], lane[2], lane[1], lane[0]};

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
        .busy     (busy),
        .wr_count (wr_count)
    );

    dff_bank_arbiter_chk #(.N_REQ(4)) u_chk (
        .clk   (clk),
        .reset (reset),
        .gnt   (gnt),
        .ack   (ack),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    function automatic int rr_model(input logic [3:0] r, input int p);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Ack monitor: every ack pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("ack_onehot", 32'(ack), 32'(onehot(mon_e.idx)));
                check_eq("gnt_in_ack", 32'(gnt), 32'(onehot(mon_e.idx)));
                check_eq("q_at_ack", 32'(q), 32'(mon_e.data));
                check_eq("count_at_ack", 32'(wr_count), 32'(mon_e.cnt));
            end
        end
    end

    // One complete write: grant at E0, ack at E1, idle after E2.
    task automatic run_txn(input logic [3:0] reqv, input int exp_w, input logic chg,
                           input logic [7:0] chg_val, input logic [3:0] req_late);
        m_cnt = m_cnt + 8'd1;
        sb.push_back('{idx: exp_w, data: lane[exp_w], cnt: m_cnt});
        m_q = lane[exp_w];
        req = reqv;
        @(negedge clk);
        check_eq("gnt_e0", 32'(gnt), 32'(onehot(exp_w)));
        check_eq("busy_grant", 32'(busy), 32'd1);
        if (chg) lane[exp_w] = chg_val;
        req = req | req_late;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check_eq("gnt_idle", 32'(gnt), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        m_ptr = (exp_w + 1) % 4;
    endtask

    initial begin
        logic [3:0] rv;
        int         w;
        reset = 1'b0;
        req   = 4'b0000;
        for (int k = 0; k < 4; k++) lane[k] = 8'h00;
        #2;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_q", 32'(q), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("idle_no_req", 32'(busy), 32'd0);

        // Fairness: all four requesting continuously, grants 0,1,2,3,0.
        lane[0] = 8'h10; lane[1] = 8'h21; lane[2] = 8'h32; lane[3] = 8'h43;
        for (int t = 0; t < 5; t++) begin
            m_cnt = m_cnt + 8'd1;
            sb.push_back('{idx: t % 4, data: lane[t % 4], cnt: m_cnt});
        end
        req = 4'b1111;
        @(negedge clk);
        check_eq("rr_first_gnt", 32'(gnt), 32'd1);
        repeat (13) @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        check_eq("rr_count", 32'(wr_count), 32'd5);
        check_eq("rr_sb_drained", 32'(sb.size()), 32'd0);
        check_eq("rr_q", 32'(q), 32'h10);
        m_ptr = 1;
        m_q   = 8'h10;

        // Single request on lane 2; pointer then sits at 3, so 1001 must pick 3.
        lane[2] = 8'hA5;
        run_txn(4'b0100, 2, 1'b0, 8'h00, 4'b0000);
        check_eq("single_q", 32'(q), 32'hA5);
        lane[3] = 8'h7E;
        run_txn(4'b1001, 3, 1'b0, 8'h00, 4'b0000);

        // Abort: requester 1 drops during GRANT.
        lane[1] = 8'h5C;
        req = 4'b0010;
        @(negedge clk);
        check_eq("abort_gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        @(negedge clk);
        check_eq("abort_gnt_clr", 32'(gnt), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_q", 32'(q), 32'(m_q));
        check_eq("abort_count", 32'(wr_count), 32'(m_cnt));
        // Pointer still 0: 1011 must go to 0, not 3.
        run_txn(4'b1011, 0, 1'b0, 8'h00, 4'b0000);

        // Data stability plus a late non-granted request during GRANT.
        lane[0] = 8'h11;
        run_txn(4'b0001, 0, 1'b1, 8'h22, 4'b0100);
        check_eq("stable_q", 32'(q), 32'h11);

        // Random traffic until the 256th completed write wraps the counter.
        while (m_cnt != 8'd0) begin
            rv = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++) lane[k] = 8'($urandom_range(0, 255));
            w = rr_model(rv, m_ptr);
            run_txn(rv, w, 1'b0, 8'h00, 4'b0000);
        end
        check_eq("wrap_count", 32'(wr_count), 32'd0);
        check_eq("wrap_q", 32'(q), 32'(m_q));

        // Reset while ack is high: everything clears with no clock edge.
        lane[0] = 8'h3C;
        m_cnt = m_cnt + 8'd1;
        sb.push_back('{idx: 0, data: 8'h3C, cnt: m_cnt});
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_ack", 32'(ack), 32'b0001);
        #1 reset = 1'b0;
        #1;
        check_eq("midack_gnt", 32'(gnt), 32'd0);
        check_eq("midack_ack", 32'(ack), 32'd0);
        check_eq("midack_q", 32'(q), 32'd0);
        check_eq("midack_busy", 32'(busy), 32'd0);
        check_eq("midack_count", 32'(wr_count), 32'd0);
        req   = 4'b0000;
        m_ptr = 0;
        m_cnt = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("post_rst_idle", 32'(busy), 32'd0);
        // Pointer cleared by reset: 1001 must pick 0.
        lane[0] = 8'h9D;
        run_txn(4'b1001, 0, 1'b0, 8'h00, 4'b0000);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
